// File: rtl/opseq_pkg.sv
// Shared constants for operand_sequencer: state codes, operand byte-slot indices
// and a small state-decode helper.
package opseq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_ALO   = 3'd0;
  localparam state_t S_AHI   = 3'd1;
  localparam state_t S_XLO   = 3'd2;
  localparam state_t S_XHI   = 3'd3;
  localparam state_t S_START = 3'd4;
  localparam state_t S_WACK  = 3'd5;
  localparam state_t S_WDONE = 3'd6;

  // The collecting states double as the byte-slot index via their low two bits.
  localparam logic [1:0] SLOT_A_LO = 2'd0;
  localparam logic [1:0] SLOT_A_HI = 2'd1;
  localparam logic [1:0] SLOT_X_LO = 2'd2;
  localparam logic [1:0] SLOT_X_HI = 2'd3;

  function automatic logic state_is_busy(input state_t s);
    return (s == S_START) || (s == S_WACK) || (s == S_WDONE);
  endfunction

endpackage

// File: rtl/operand_sequencer_key_edge.sv
// Push-button synchroniser and rising-edge detector (module key_edge).
// The pulse is combinational from the flops, so the consumer acts on the 3rd edge.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic keyIn,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q;
  logic valid1_q, valid2_q, armed_q;

  // armed_q only sets once the synchronised key has been seen low after reset,
  // so a button already held through reset release cannot fire a capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= keyIn;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      valid1_q <= 1'b1;
      valid2_q <= valid1_q;
      if (valid2_q && !sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign pulse = sync2_q & ~prev_q & armed_q;

endmodule

// File: rtl/operand_sequencer.sv
// Collects four bytes from a push button into operands A and X, then handshakes
// with a multiply core. Optional mid-sequence idle timeout: define OPSEQ_TIMEOUT_EN.
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int N              = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           keyIn,
  input  logic [N/2-1:0] inBus,
  input  logic           readyIn,
  output logic [N-1:0]   opA,
  output logic [N-1:0]   opX,
  output logic           startOut,
  output logic           busy,
  output logic [2:0]     phase,
  output logic           errTimeout
);

  localparam int B = N / 2;

  logic         capture;
  logic         timeout;
  state_t       state_q, state_d;
  logic [N-1:0] opA_q, opA_d;
  logic [N-1:0] opX_q, opX_d;

  key_edge u_key_edge (
    .clk   (clk),
    .rst   (rst),
    .keyIn (keyIn),
    .pulse (capture)
  );

`ifdef OPSEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] idleCnt_q, idleCnt_d;
  logic          errTimeout_q, errTimeout_d;
  logic          collecting;

  assign collecting = (state_q == S_AHI) || (state_q == S_XLO) || (state_q == S_XHI);

  // The count restarts on every capture and whenever the sequence is not mid-way.
  always_comb begin
    idleCnt_d    = '0;
    timeout      = 1'b0;
    errTimeout_d = errTimeout_q;
    if (collecting && !capture) begin
      if (idleCnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        idleCnt_d = idleCnt_q + CW'(1);
      end
    end
    if (timeout) begin
      errTimeout_d = 1'b1;
    end else if (capture && (state_q == S_ALO)) begin
      errTimeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idleCnt_q    <= '0;
      errTimeout_q <= 1'b0;
    end else begin
      idleCnt_q    <= idleCnt_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  assign errTimeout = errTimeout_q;
`else
  logic unusedTimeoutCfg;

  assign timeout          = 1'b0;
  assign errTimeout       = 1'b0;
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opX_d   = opX_q;
    case (state_q)
      S_ALO, S_AHI, S_XLO, S_XHI: begin
        if (capture) begin
          case (state_q[1:0])
            SLOT_A_LO: opA_d[B-1:0] = inBus;
            SLOT_A_HI: opA_d[N-1:B] = inBus;
            SLOT_X_LO: opX_d[B-1:0] = inBus;
            default:   opX_d[N-1:B] = inBus;
          endcase
          state_d = state_q + 3'd1;
        end else if (timeout) begin
          state_d = S_ALO;
        end
      end
      S_START: state_d = S_WACK;
      S_WACK:  if (!readyIn) state_d = S_WDONE;
      S_WDONE: if (readyIn) state_d = S_ALO;
      default: state_d = S_ALO;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_ALO;
      opA_q   <= '0;
      opX_q   <= '0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opX_q   <= opX_d;
    end
  end

  assign opA      = opA_q;
  assign opX      = opX_q;
  assign startOut = (state_q == S_START);
  assign busy     = state_is_busy(state_q);
  assign phase    = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: directed sequences, a vector table
// and randomized presses/handshakes against a byte-collection model.
module tb_operand_sequencer;

  localparam int N = 16;
`ifdef OPSEQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        keyIn = 1'b0;
  logic        readyIn = 1'b1;
  logic [7:0]  inBus = 8'h00;
  logic [15:0] opA, opX;
  logic        startOut, busy, errTimeout;
  logic [2:0]  phase;

  int checks = 0;
  int failures = 0;
  int startCount = 0;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] expA, expX;
  } vec_t;

  vec_t vecs [4];

  logic [7:0] mBytes [4];
  int         mCount;
  bit         mBusy;
  int         mStarts;

  operand_sequencer #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .keyIn      (keyIn),
    .inBus      (inBus),
    .readyIn    (readyIn),
    .opA        (opA),
    .opX        (opX),
    .startOut   (startOut),
    .busy       (busy),
    .phase      (phase),
    .errTimeout (errTimeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (startOut) startCount++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    keyIn = 1'b0;
    readyIn = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(5);
    for (int i = 0; i < 4; i++) mBytes[i] = 8'h00;
    mCount = 0;
    mBusy = 1'b0;
  endtask

  task automatic pressKey(input logic [7:0] val, input int hold);
    inBus = val;
    keyIn = 1'b1;
    tick(hold);
    keyIn = 1'b0;
    tick(4);
  endtask

  task automatic completeCore(input int lowCycles);
    readyIn = 1'b0;
    tick(lowCycles);
    readyIn = 1'b1;
    tick(2);
  endtask

  task automatic applyStimulus(input vec_t v, input logic [15:0] prevA, input logic [15:0] prevX);
    pressKey(v.b0, 4);
    @(negedge clk);
    checkOutput("tbl_partial_opA", 32'(opA), 32'({prevA[15:8], v.b0}));
    checkOutput("tbl_partial_opX", 32'(opX), 32'(prevX));
    pressKey(v.b1, 3);
    pressKey(v.b2, 5);
    pressKey(v.b3, 4);
    @(negedge clk);
    checkOutput("tbl_opA", 32'(opA), 32'(v.expA));
    checkOutput("tbl_opX", 32'(opX), 32'(v.expX));
    checkOutput("tbl_phase_wack", 32'(phase), 32'd5);
    completeCore(2);
    @(negedge clk);
    checkOutput("tbl_phase_idle", 32'(phase), 32'd0);
    checkOutput("tbl_busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic modelPress(input logic [7:0] val);
    if (!mBusy) begin
      mBytes[mCount] = val;
      mCount++;
      if (mCount == 4) begin
        mCount = 0;
        mBusy = 1'b1;
        mStarts++;
      end
    end
  endtask

  task automatic compareModel();
    checkOutput("rnd_opA", 32'(opA), 32'({mBytes[1], mBytes[0]}));
    checkOutput("rnd_opX", 32'(opX), 32'({mBytes[3], mBytes[2]}));
    checkOutput("rnd_busy", 32'(busy), 32'(mBusy));
    checkOutput("rnd_phase", 32'(phase), mBusy ? 32'd5 : 32'(mCount));
    checkOutput("rnd_starts", 32'(startCount), 32'(mStarts));
  endtask

  initial begin
    logic [15:0] prevA, prevX;
    int          startBase;

    vecs[0] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 16'hFF00, 16'h5AA5};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{8'h01, 8'h80, 8'h7F, 8'hFE, 16'h8001, 16'hFE7F};
    vecs[3] = '{8'hC3, 8'h3C, 8'h00, 8'h00, 16'h3CC3, 16'h0000};

    tick(3);
    @(negedge clk);
    checkOutput("rst_opA", 32'(opA), 32'd0);
    checkOutput("rst_opX", 32'(opX), 32'd0);
    checkOutput("rst_start", 32'(startOut), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_phase", 32'(phase), 32'd0);
    checkOutput("rst_err", 32'(errTimeout), 32'd0);
    doReset();

    // Four presses: first one checks capture lands exactly on the 3rd edge.
    inBus = 8'h12;
    keyIn = 1'b1;
    tick(2);
    @(negedge clk);
    checkOutput("edge2_no_capture", 32'(phase), 32'd0);
    tick(1);
    @(negedge clk);
    checkOutput("edge3_capture_phase", 32'(phase), 32'd1);
    checkOutput("edge3_capture_opA", 32'(opA), 32'h0012);
    keyIn = 1'b0;
    tick(4);
    pressKey(8'h34, 4);
    pressKey(8'h56, 4);
    inBus = 8'h78;
    keyIn = 1'b1;
    tick(3);
    @(negedge clk);
    checkOutput("seq_phase_start", 32'(phase), 32'd4);
    checkOutput("seq_startOut", 32'(startOut), 32'd1);
    checkOutput("seq_busy_start", 32'(busy), 32'd1);
    checkOutput("seq_opA", 32'(opA), 32'h3412);
    checkOutput("seq_opX", 32'(opX), 32'h7856);
    tick(1);
    @(negedge clk);
    checkOutput("seq_phase_wack", 32'(phase), 32'd5);
    checkOutput("seq_startOut_low", 32'(startOut), 32'd0);
    checkOutput("seq_busy_wack", 32'(busy), 32'd1);
    keyIn = 1'b0;
    tick(4);
    checkOutput("seq_one_start", 32'(startCount), 32'd1);

    pressKey(8'hFF, 4);
    @(negedge clk);
    checkOutput("busy_press_opA", 32'(opA), 32'h3412);
    checkOutput("busy_press_opX", 32'(opX), 32'h7856);
    checkOutput("busy_press_phase", 32'(phase), 32'd5);

    tick(1);
    readyIn = 1'b0;
    tick(1);
    @(negedge clk);
    checkOutput("ack_phase_wdone", 32'(phase), 32'd6);
    checkOutput("ack_busy_wdone", 32'(busy), 32'd1);
    tick(1);
    readyIn = 1'b1;
    @(negedge clk);
    checkOutput("ack_busy_before_edge", 32'(busy), 32'd1);
    tick(1);
    @(negedge clk);
    checkOutput("ack_busy_fall", 32'(busy), 32'd0);
    checkOutput("ack_phase_idle", 32'(phase), 32'd0);
    checkOutput("ack_opA_held", 32'(opA), 32'h3412);
    checkOutput("ack_start_total", 32'(startCount), 32'd1);

    prevA = 16'h3412;
    prevX = 16'h7856;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i], prevA, prevX);
      prevA = vecs[i].expA;
      prevX = vecs[i].expX;
      tick(1);
    end

    // A long hold produces a single capture; with the timeout it then aborts.
    inBus = 8'h9C;
    keyIn = 1'b1;
    tick(50);
    keyIn = 1'b0;
    tick(4);
    @(negedge clk);
    checkOutput("hold50_opA_lo", 32'(opA[7:0]), 32'h9C);
`ifdef OPSEQ_TIMEOUT_EN
    checkOutput("hold50_phase", 32'(phase), 32'd0);
    checkOutput("hold50_err", 32'(errTimeout), 32'd1);
`else
    checkOutput("hold50_phase", 32'(phase), 32'd1);
`endif

    doReset();
    pressKey(8'h11, 4);
    pressKey(8'h22, 4);
    pressKey(8'h33, 4);
    @(negedge clk);
    checkOutput("xhi_phase", 32'(phase), 32'd3);
    tick(1);
    inBus = 8'h44;
    keyIn = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_opA", 32'(opA), 32'd0);
    checkOutput("async_rst_opX", 32'(opX), 32'd0);
    checkOutput("async_rst_phase", 32'(phase), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_start", 32'(startOut), 32'd0);
    checkOutput("async_rst_err", 32'(errTimeout), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(10);
    @(negedge clk);
    checkOutput("held_key_no_capture_phase", 32'(phase), 32'd0);
    checkOutput("held_key_no_capture_opA", 32'(opA), 32'd0);
    keyIn = 1'b0;
    tick(4);
    pressKey(8'h55, 4);
    @(negedge clk);
    checkOutput("fresh_press_phase", 32'(phase), 32'd1);
    checkOutput("fresh_press_opA", 32'(opA), 32'h0055);

`ifdef OPSEQ_TIMEOUT_EN
    doReset();
    inBus = 8'hA1;
    keyIn = 1'b1;
    tick(3);
    keyIn = 1'b0;
    tick(15);
    @(negedge clk);
    checkOutput("to_before_phase", 32'(phase), 32'd1);
    checkOutput("to_before_err", 32'(errTimeout), 32'd0);
    tick(1);
    @(negedge clk);
    checkOutput("to_phase", 32'(phase), 32'd0);
    checkOutput("to_err", 32'(errTimeout), 32'd1);
    tick(1);
    pressKey(8'hB2, 4);
    @(negedge clk);
    checkOutput("to_clear_err", 32'(errTimeout), 32'd0);
    checkOutput("to_clear_phase", 32'(phase), 32'd1);
    checkOutput("to_clear_opA", 32'(opA[7:0]), 32'hB2);
`endif

    doReset();
    startBase = startCount;
    mStarts = startBase;
    for (int it = 0; it < 40; it++) begin
      logic [7:0] val;
      val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) < 3) begin
        pressKey(val, int'($urandom_range(3, 8)));
        modelPress(val);
      end else begin
`ifdef OPSEQ_TIMEOUT_EN
        if (mBusy) begin
          completeCore(int'($urandom_range(1, 4)));
          mBusy = 1'b0;
        end
`else
        completeCore(int'($urandom_range(1, 4)));
        mBusy = 1'b0;
`endif
      end
      @(negedge clk);
      compareModel();
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, giving the operand width; the byte width is N/2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the idle cycles allowed mid-sequence (used only under OPSEQ_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port keyIn, input, 1 bit: raw, asynchronous byte-enter push button.
REQ-006 SHALL have port inBus, input, N/2 bits: byte switches, sampled on capture.
REQ-007 SHALL have port readyIn, input, 1 bit: ready from the downstream multiply core.
REQ-008 SHALL have port opA, output, N bits: assembled A operand.
REQ-009 SHALL have port opX, output, N bits: assembled X operand.
REQ-010 SHALL have port startOut, output, 1 bit: one-cycle start pulse to the core.
REQ-011 SHALL have port busy, output, 1 bit: high from the start pulse until the core completes.
REQ-012 SHALL have port phase, output, 3 bits: current state code for the LEDs.
REQ-013 SHALL have port errTimeout, output, 1 bit: sticky abort flag.

Function
REQ-014 SHALL pass keyIn through a 2-flop synchroniser and rising-edge detector; each press yields exactly one capture pulse on the 3rd rising clk edge after keyIn rises.
REQ-015 SHALL implement states S_ALO=0, S_AHI=1, S_XLO=2, S_XHI=3, S_START=4, S_WACK=5, S_WDONE=6.
REQ-016 SHALL, on a capture in S_ALO, S_AHI, S_XLO or S_XHI, load inBus into opA[N/2-1:0], opA[N-1:N/2], opX[N/2-1:0] or opX[N-1:N/2] respectively, and advance one state.
REQ-017 SHALL leave the unwritten operand bytes unchanged on each capture.
REQ-018 SHALL assert startOut for exactly the one cycle spent in S_START, then go to S_WACK.
REQ-019 SHALL, in S_WACK, wait for readyIn=0; in S_WDONE, wait for readyIn=1; then return to S_ALO.
REQ-020 SHALL drive busy=1 in S_START, S_WACK and S_WDONE, and 0 elsewhere.
REQ-021 SHALL ignore and discard captures in S_START, S_WACK and S_WDONE.
REQ-022 SHALL hold opA and opX stable from S_START until the return to S_ALO.
REQ-023 SHALL drive phase equal to the state code.
REQ-024 SHALL not time out in S_WACK or S_WDONE; a core that never responds holds the block busy until reset.
REQ-025 SHALL clear errTimeout on the first capture in S_ALO.

Reset
REQ-026 SHALL, on rst=0 (asynchronous, including mid-operation), force state S_ALO, opA=0, opX=0, startOut=0, busy=0, phase=0, errTimeout=0, clear the synchroniser and edge flops, and clear the timeout counter.
REQ-027 SHALL not produce a spurious capture after reset release when keyIn is already high; the edge flop resets to 0 and the next capture needs a fresh press.

Configuration
REQ-028 SHALL, with OPSEQ_TIMEOUT_EN defined, count cycles without a capture in S_AHI, S_XLO and S_XHI, reset the count on each capture, and on reaching TIMEOUT_CYCLES return to S_ALO and set errTimeout.
REQ-029 SHALL, with OPSEQ_TIMEOUT_EN undefined, contain no counter, tie errTimeout to 0, and never time out.

Structure
REQ-030 SHALL place the state encoding constants and the byte-slot index constants in the shared package opseq_pkg.
REQ-031 SHALL contain the synchroniser and edge detector as sub-module key_edge (ports clk, rst, keyIn, pulse).

Verification
REQ-032 SHALL cover: reset, then 4 presses with inBus=12,34,56,78 -> opA=0x3412, opX=0x7856, one startOut pulse, busy=1, phase=4 then 5.
REQ-033 SHALL cover: in S_WACK, readyIn 1->0->1 -> busy falls one cycle after readyIn returns to 1, and phase=0.
REQ-034 SHALL cover: a fifth press while busy with inBus=FF -> opA and opX unchanged, and phase stays in the wait states.
REQ-035 SHALL cover: keyIn held high for 50 cycles -> exactly one capture.
REQ-036 SHALL cover: rst pulsed low in S_XHI -> all outputs 0 immediately, phase=0, with no capture if keyIn is still high.
REQ-037 SHALL cover: with OPSEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, one press then 16 idle cycles -> phase=0 and errTimeout=1; the next press clears errTimeout.
